adc_capture_buffer: RTL and testbench

ADC_CAPTURE_BUFFER -- requirements
Module: adc_capture_buffer

---
 rtl/adc_capture_buffer.sv | 181 ++++++++++++++++++
 tb/tb_adc_capture_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_buffer.sv
// Multi-channel ADC capture buffer: pre/post-trigger circular capture into a
// DEPTH-deep sample RAM, then an oldest-first valid/ready readout stream.
module adc_capture_buffer #(
  parameter  int N_CH  = 4,
  parameter  int DW    = 12,
  parameter  int DEPTH = 1024,
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*DW-1:0]   adc_data,
  input  logic                 fmt_twos,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [1:0]           trig_mode,
  input  logic [CW-1:0]        trig_ch,
  input  logic [DW-1:0]        trig_level,
  input  logic                 ext_trig,
  input  logic [AW-1:0]        pretrig,
  output logic [N_CH*DW-1:0]   rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 rd_last,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FILL = 3'd1, S_WAIT = 3'd2, S_POST = 3'd3, S_READ = 3'd4
  } state_t;

  localparam logic [1:0] M_IMM = 2'b00, M_RISE = 2'b01, M_FALL = 2'b10, M_EXT = 2'b11;

  state_t              state_q;
  logic [N_CH*DW-1:0]  adc_q, conv_d;
  logic [AW-1:0]       wptr_q, rptr_q, cnt_q, pretrig_q;
  logic [1:0]          mode_q;
  logic [CW-1:0]       ch_q;
  logic [DW-1:0]       lvl_q, prev_q, cur_d;
  logic                prev_vld_q;
  logic [N_CH*DW-1:0]  rd_data_q;
  logic                rd_valid_q, rd_last_q;
  logic                prev_lt, prev_gt, cur_ge, cur_le, trig_hit, we;
  logic [AW-1:0]       post_last;

  logic [N_CH*DW-1:0]  mem [DEPTH];

  // Offset-binary to two's complement is just an MSB flip per channel.
  for (genvar k = 0; k < N_CH; k++) begin : g_conv
    assign conv_d[k*DW +: DW] = {adc_q[k*DW+DW-1] ^ fmt_twos, adc_q[k*DW +: DW-1]};
  end

  assign cur_d = conv_d[int'(ch_q)*DW +: DW];

  always_comb begin
    if (fmt_twos) begin
      prev_lt = $signed(prev_q) <  $signed(lvl_q);
      prev_gt = $signed(prev_q) >  $signed(lvl_q);
      cur_ge  = $signed(cur_d)  >= $signed(lvl_q);
      cur_le  = $signed(cur_d)  <= $signed(lvl_q);
    end else begin
      prev_lt = prev_q < lvl_q;
      prev_gt = prev_q > lvl_q;
      cur_ge  = cur_d >= lvl_q;
      cur_le  = cur_d <= lvl_q;
    end
  end

  // prev_vld_q blocks a crossing against a stale prev on the first WAIT sample.
  always_comb begin
    trig_hit = 1'b0;
    case (mode_q)
      M_IMM:   trig_hit = 1'b1;
      M_RISE:  trig_hit = prev_vld_q && prev_lt && cur_ge;
      M_FALL:  trig_hit = prev_vld_q && prev_gt && cur_le;
      M_EXT:   trig_hit = ext_trig;
      default: trig_hit = 1'b0;
    endcase
  end

  assign post_last = AW'(DEPTH - 2) - pretrig_q;
  assign we = !rst && !abort &&
              (state_q == S_FILL || state_q == S_WAIT || state_q == S_POST);

  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= conv_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      adc_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      pretrig_q  <= '0;
      mode_q     <= '0;
      ch_q       <= '0;
      lvl_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      adc_q <= adc_data;
      if (abort) begin
        state_q    <= S_IDLE;
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (arm) begin
            pretrig_q  <= pretrig;
            mode_q     <= trig_mode;
            ch_q       <= trig_ch;
            lvl_q      <= trig_level;
            wptr_q     <= '0;
            cnt_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            state_q    <= (pretrig == '0) ? S_WAIT : S_FILL;
          end
          S_FILL: begin
            wptr_q     <= wptr_q + AW'(1);
            cnt_q      <= cnt_q + AW'(1);
            prev_q     <= cur_d;
            prev_vld_q <= 1'b1;
            if (cnt_q == pretrig_q - AW'(1)) state_q <= S_WAIT;
          end
          S_WAIT: begin
            wptr_q     <= wptr_q + AW'(1);
            prev_q     <= cur_d;
            prev_vld_q <= 1'b1;
            if (trig_hit) begin
              rptr_q  <= wptr_q - pretrig_q;
              cnt_q   <= '0;
              state_q <= (pretrig_q == AW'(DEPTH - 1)) ? S_READ : S_POST;
            end
          end
          S_POST: begin
            wptr_q <= wptr_q + AW'(1);
            cnt_q  <= cnt_q + AW'(1);
            if (cnt_q == post_last) begin
              cnt_q   <= '0;
              state_q <= S_READ;
            end
          end
          S_READ: begin
            // Output register holds the presented beat; the RAM is re-read only on advance.
            if (!rd_valid_q) begin
              rd_valid_q <= 1'b1;
              rd_last_q  <= 1'b0;
              rd_data_q  <= mem[rptr_q];
            end else if (rd_ready) begin
              if (rd_last_q) begin
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
                rd_data_q  <= '0;
                state_q    <= S_IDLE;
              end else begin
                rptr_q    <= rptr_q + AW'(1);
                cnt_q     <= cnt_q + AW'(1);
                rd_data_q <= mem[rptr_q + AW'(1)];
                rd_last_q <= (cnt_q == AW'(DEPTH - 2));
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign state    = state_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer: table of capture scenarios driven by a
// per-cycle ramp generator, plus abort/reset/arm-ignore sequences.
module tb_adc_capture_buffer;
  localparam int N_CH = 4, DW = 12, DEPTH = 16, CW = 2, AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, fmt_twos, arm, abort, ext_trig, rd_valid, rd_ready, rd_last;
  logic [N_CH*DW-1:0]  adc_data, rd_data;
  logic [1:0]          trig_mode;
  logic [CW-1:0]       trig_ch;
  logic [DW-1:0]       trig_level;
  logic [AW-1:0]       pretrig;
  logic [2:0]          state;

  adc_capture_buffer #(.N_CH(N_CH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .fmt_twos(fmt_twos), .arm(arm),
    .abort(abort), .trig_mode(trig_mode), .trig_ch(trig_ch), .trig_level(trig_level),
    .ext_trig(ext_trig), .pretrig(pretrig), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .state(state)
  );

  // tr = raw ch0 value of the trigger sample; beats step by `step` around it.
  typedef struct {
    int         pt;
    logic [1:0] mode;
    int         ch;
    logic [11:0] lvl;
    logic       fmt;
    logic [11:0] r0;
    logic [11:0] step;
    logic [31:0] mask;
    logic [11:0] tr;
    logic       tog;
  } scn_t;

  scn_t        tbl [7];
  int          n_cmp = 0, n_bad = 0, cur_id = -1;
  int          gn = 0;
  logic [11:0] g_r0 = '0, g_step = 12'h001;
  logic [31:0] g_mask = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (case %0d): got %0h expected %0h", name, cur_id, act, exp);
    end
  endtask

  // Channel k carries r+k; f applies the MSB flip the DUT should apply.
  function automatic logic [47:0] cword(input logic [11:0] r, input logic f);
    logic [47:0] w;
    for (int k = 0; k < 4; k++) begin
      w[k*12 +: 12] = r + 12'(k);
      if (f) w[k*12+11] = ~w[k*12+11];
    end
    return w;
  endfunction

  task automatic drive_gen();
    adc_data = cword(g_r0 + 12'(gn) * g_step, 1'b0);
    ext_trig = (gn < 32) ? g_mask[gn] : 1'b0;
    gn++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    arm   = 1'b0;
    abort = 1'b0;
    drive_gen();
  endtask

  task automatic start(input int pt, input logic [1:0] mode, input int ch,
                       input logic [11:0] lvl, input logic fmt, input logic [11:0] r0,
                       input logic [11:0] step, input logic [31:0] mask);
    pretrig    = 4'(pt);
    trig_mode  = mode;
    trig_ch    = 2'(ch);
    trig_level = lvl;
    fmt_twos   = fmt;
    g_r0 = r0; g_step = step; g_mask = mask; gn = 0;
    drive_gen();
    arm = 1'b1;
  endtask

  task automatic run_scn(input scn_t s);
    int t, cyc, got, first;
    logic stalled, held_last;
    logic [47:0] held, exp;
    start(s.pt, s.mode, s.ch, s.lvl, s.fmt, s.r0, s.step, s.mask);
    t = 0;
    while (state !== 3'd4 && t < 300) begin
      tick(); t++;
      if (state !== 3'd4) chk("valid_before_read", rd_valid, 0);
    end
    chk("reach_read", state, 4);
    cyc = 0; got = 0; first = -1; stalled = 0; held = '0; held_last = 0;
    while (got < DEPTH && cyc < 100) begin
      rd_ready = s.tog ? ~cyc[0] : 1'b1;
      if (rd_valid) begin
        if (first < 0) first = cyc;
        if (stalled) begin
          chk("stall_data", rd_data, held);
          chk("stall_last", rd_last, held_last);
        end
        if (rd_ready) begin
          exp = cword(s.tr + 12'(got - s.pt) * s.step, s.fmt);
          chk("beat_data", rd_data, exp);
          chk("beat_last", rd_last, got == DEPTH - 1);
          got++; stalled = 0;
        end else begin
          stalled = 1; held = rd_data; held_last = rd_last;
        end
      end else if (first >= 0) chk("valid_drop", rd_valid, 1);
      tick(); cyc++;
    end
    rd_ready = 1'b0;
    chk("beat_count", got, DEPTH);
    chk("first_latency", first >= 0 && first <= 2, 1);
    chk("idle_after", state, 0);
    chk("valid_after", rd_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            pt mode  ch lvl     fmt r0      step    mask         tr      tog
    tbl[0] = '{4,  2'b01, 0, 12'h010, 0, 12'h000, 12'h001, 32'h0,     12'h010, 0};
    tbl[1] = '{4,  2'b10, 0, 12'h000, 1, 12'h813, 12'hFFE, 32'h0,     12'h7FF, 0};
    tbl[2] = '{0,  2'b00, 0, 12'h000, 0, 12'h100, 12'h001, 32'h0,     12'h100, 0};
    tbl[3] = '{2,  2'b01, 2, 12'h050, 0, 12'h040, 12'h001, 32'h0,     12'h04E, 1};
    tbl[4] = '{15, 2'b01, 0, 12'h030, 0, 12'h020, 12'h001, 32'h0,     12'h030, 0};
    tbl[5] = '{0,  2'b01, 0, 12'h010, 0, 12'h012, 12'hFFF, 32'h0,     12'hFFF, 1};
    tbl[6] = '{3,  2'b11, 0, 12'h000, 0, 12'h200, 12'h001, 32'h206,   12'h208, 0};

    rst = 1'b1; arm = 0; abort = 0; rd_ready = 0; fmt_twos = 0; trig_mode = 0;
    trig_ch = 0; trig_level = 0; pretrig = 0; ext_trig = 0; adc_data = '0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_data", rd_data, 0);
    rst = 1'b0;
    tick();

    // Abort while waiting for an unreachable trigger.
    cur_id = 100;
    start(4, 2'b01, 0, 12'hFFF, 0, 12'h000, 12'h001, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("wait_before_abort", state, 2);
    abort = 1'b1;
    tick();
    chk("abort_state", state, 0);
    chk("abort_valid", rd_valid, 0);
    tick();
    chk("abort_stays_idle", state, 0);

    // Reset in the middle of readout, with beat 7 presented.
    cur_id = 101;
    rd_ready = 1'b1;
    start(0, 2'b00, 0, 12'h000, 0, 12'h300, 12'h001, 0);
    for (int t = 0; t < 100 && rd_valid !== 1'b1; t++) tick();
    chk("rst_seq_valid", rd_valid, 1);
    for (int i = 0; i < 7; i++) tick();
    chk("rst_seq_beat7", rd_data, cword(12'h307, 0));
    rd_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_read_state", state, 0);
    chk("rst_read_valid", rd_valid, 0);
    chk("rst_read_last", rd_last, 0);
    chk("rst_read_data", rd_data, 0);
    rst = 1'b0;
    tick();

    // arm ignored in POST; abort beats a simultaneous arm.
    cur_id = 102;
    start(4, 2'b00, 0, 12'h000, 0, 12'h400, 12'h001, 0);
    for (int t = 0; t < 50 && state !== 3'd3; t++) tick();
    chk("reach_post", state, 3);
    pretrig = 4'd0;
    arm = 1'b1;
    tick();
    chk("arm_in_post_ignored", state, 3);
    abort = 1'b1; arm = 1'b1;
    tick();
    chk("abort_post_state", state, 0);
    chk("abort_post_valid", rd_valid, 0);
    abort = 1'b1; arm = 1'b1;
    tick();
    chk("abort_wins_idle", state, 0);

    for (int i = 0; i < 7; i++) begin
      cur_id = i;
      run_scn(tbl[i]);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
